// File: rtl/md_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the multiply/divide sequencer.
package md_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration on {acc,q}: LSB-first shift-add multiply or restoring divide.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_acc} + {1'b0, i_b};
        w_shl  = {i_acc, i_q[WIDTH-1]};
        w_diff = w_shl - {1'b0, i_b};
        o_acc  = i_acc;
        o_q    = i_q;
        if (i_div) begin
            // acc < divisor is invariant, so the borrow is exactly bit WIDTH
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shl[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end else if (i_q[0]) begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[WIDTH-1:1]};
            o_q   = {i_acc[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (MTHI/MTLO writes when idle).
// Optional MD_DIVZERO_EN: short-circuits divide-by-zero and adds the div_zero pulse output.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
`ifdef MD_DIVZERO_EN
    output logic             div_zero,
`endif
    output logic             md_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc, r_q, r_b;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_done;
    logic [WIDTH-1:0]   w_acc_nxt, w_q_nxt;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_hi_fix, w_lo_fix;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_sgn, w_accept, w_dz_start;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign w_accept = (r_state == MD_IDLE) && md_start;
    assign w_sgn    = op_is_signed(md_op);
    assign w_abs_a  = abs_val(md_a, w_sgn);
    assign w_abs_b  = abs_val(md_b, w_sgn);

`ifdef MD_DIVZERO_EN
    assign w_dz_start = op_is_div(md_op) && (md_b == '0);
`else
    assign w_dz_start = 1'b0;
`endif

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_b   (r_b),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (md_start) w_state_nxt = w_dz_start ? MD_FIX : MD_CALC;
            MD_CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Sign correction of the unsigned magnitude result
    assign w_prod   = neg_2w({r_acc, r_q}, r_neg_q);
    assign w_hi_fix = r_div ? neg_w(r_acc, r_neg_r) : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_fix = r_div ? neg_w(r_q, r_neg_q)   : w_prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == MD_FIX);
            case (r_state)
                MD_IDLE: begin
                    if (md_start) begin
                        r_cnt <= '0;
                    end else begin
                        if (hi_we) r_hi <= wr_data;
                        if (lo_we) r_lo <= wr_data;
                    end
                end
                MD_CALC: r_cnt <= r_cnt + CNT_W'(1);
                MD_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    // Operand datapath: loaded at accept, stepped during CALC
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_div   <= op_is_div(md_op);
            r_acc   <= '0;
            r_neg_q <= w_sgn && (md_a[WIDTH-1] ^ md_b[WIDTH-1]);
            r_neg_r <= w_sgn && md_a[WIDTH-1] && op_is_div(md_op);
            if (w_dz_start) begin
                r_acc   <= md_a;
                r_q     <= '1;
                r_b     <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (op_is_div(md_op)) begin
                r_q <= w_abs_a;
                r_b <= w_abs_b;
            end else begin
                r_q <= w_abs_b;
                r_b <= w_abs_a;
            end
        end else if (r_state == MD_CALC) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
        end
    end

`ifdef MD_DIVZERO_EN
    logic r_dz_flag, r_div_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dz_flag  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept) r_dz_flag <= w_dz_start;
            r_div_zero <= (r_state == MD_FIX) && r_dz_flag;
        end
    end

    assign div_zero = r_div_zero;
`endif

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign md_busy = (r_state != MD_IDLE);
    assign md_done = r_done;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: mul/div results, latency, busy-time interference, reset abort.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a, md_b, wr_data;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        md_busy, md_done;
`ifdef MD_DIVZERO_EN
    logic        div_zero;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    md_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wr_data  (wr_data),
        .hi       (hi),
        .lo       (lo),
        .md_busy  (md_busy),
`ifdef MD_DIVZERO_EN
        .div_zero (div_zero),
`endif
        .md_done  (md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        tick();
        md_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (md_busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start_op(op, a, b);
        wait_idle(n);
        chk({tag, "_busy"}, n, 33);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_done"}, md_done, 1);
        tick();
        chk({tag, "_done_clr"}, md_done, 0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; md_start = 1'b0; md_op = 2'b00; md_a = '0; md_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_nn", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        // MTHI / MTLO while idle
        hi_we = 1'b1; wr_data = 32'hA5A5_0001; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wr_data = 32'h5A5A_0002; tick(); lo_we = 1'b0;
        chk("mthi", hi, 32'hA5A5_0001);
        chk("mtlo", lo, 32'h5A5A_0002);

        // Start and write strobe in the same idle cycle: start wins
        md_start = 1'b1; md_op = 2'b11; md_a = 32'd100; md_b = 32'd7;
        hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        md_start = 1'b0; hi_we = 1'b0;
        chk("start_wins_busy", md_busy, 1);
        chk("start_wins_hi", hi, 32'hA5A5_0001);
        wait_idle(n);
        chk("start_wins_res_hi", hi, 32'd2);
        chk("start_wins_res_lo", lo, 32'd14);
        tick();

        // Start + MTHI during busy cycle 5 are both ignored
        start_op(2'b11, 32'd100, 32'd7);
        repeat (4) tick();
        md_start = 1'b1; md_op = 2'b01; md_a = 32'h1234; md_b = 32'h10;
        hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        md_start = 1'b0; hi_we = 1'b0;
        chk("intf_hi_mid", hi, 32'd2);
        wait_idle(n);
        chk("intf_busy", n + 5, 33);
        chk("intf_hi", hi, 32'd2);
        chk("intf_lo", lo, 32'd14);
        tick();
        chk("intf_no_restart", md_busy, 0);

        // Reset in the middle of an op aborts it
        lo_we = 1'b1; wr_data = 32'h7777; tick(); lo_we = 1'b0;
        start_op(2'b11, 32'd100, 32'd7);
        repeat (9) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_busy", md_busy, 0);
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) pulses++;
            tick();
        end
        chk("rstmid_nodone", pulses, 0);
        lo_we = 1'b1; wr_data = 32'h1234; tick(); lo_we = 1'b0;
        chk("mtlo_after_rst", lo, 32'h1234);

        // Divide by zero
        start_op(2'b11, 32'h55, 32'h0);
        wait_idle(n);
`ifdef MD_DIVZERO_EN
        chk("dz_busy", n, 1);
        chk("dz_flag", div_zero, 1);
`else
        chk("dz_busy", n, 33);
`endif
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_done", md_done, 1);
        tick();
        chk("dz_done_clr", md_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
